x1_gram_shifter: RTL and testbench

Graphics-plane pixel fetch and serializer for the X1 video path. It sits directly downstream of the SRAM controller's video port. It drives the 14-bit GRAM address, captures the blue/red/green plane bytes after a fixed read latency, and double-buffers them. It then shifts the bytes out MSB-first on the pixel clock enable and maps each 3-bit plane index through the X1 palette registers to a 1-bit-per-gun RGB pixel.

---
 rtl/x1_gram_shifter.sv | 184 ++++++++++++++++++
 tb/tb_x1_gram_shifter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x1_gram_shifter.sv
//------------------------------------------------------------------------------
// x1_gram_shifter
//   Graphics-plane pixel fetch and serializer for the X1 video path.
//   Fetches B/R/G plane bytes from GRAM, double-buffers them, shifts them out
//   MSB-first on the pixel enable and maps each index through the palette.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module x1_gram_shifter #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_pix,
  input  logic        line_start,
  input  logic [13:0] row_base,
  input  logic        active,
  output logic [13:0] gram_a,
  input  logic [7:0]  gram_d_b,
  input  logic [7:0]  gram_d_r,
  input  logic [7:0]  gram_d_g,
  input  logic [7:0]  pal_b,
  input  logic [7:0]  pal_r,
  input  logic [7:0]  pal_g,
  output logic        b,
  output logic        r,
  output logic        g,
  output logic        underrun
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;
  logic [2:0]  wait_cnt_nxt;

  logic [7:0]  buf_b;
  logic [7:0]  buf_r;
  logic [7:0]  buf_g;
  logic [7:0]  sh_b;
  logic [7:0]  sh_r;
  logic [7:0]  sh_g;
  logic        sh_valid;
  logic [2:0]  bit_cnt;
  // Fetching is armed only by a line start, so nothing is fetched after reset.
  logic        run;

  logic        xfer;
  logic        latch;
  logic [2:0]  idx;

  assign xfer  = !sh_valid && (state == ST_FULL) && (bit_cnt == 3'd0) && !line_start;
  assign latch = (state == ST_WAIT) && (wait_cnt == 3'd1) && !line_start;
  assign idx   = {sh_g[7], sh_r[7], sh_b[7]};

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Fetch FSM next state: a line start always aborts back to IDLE.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (line_start) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = LAT;
          end
        end
        ST_WAIT: begin
          wait_cnt_nxt = wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Address counter, run flag and fetch buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gram_a <= 14'd0;
      run    <= 1'b0;
      buf_b  <= 8'd0;
      buf_r  <= 8'd0;
      buf_g  <= 8'd0;
    end else if (line_start) begin
      gram_a <= row_base;
      run    <= 1'b1;
    end else if (latch) begin
      gram_a <= gram_a + 14'd1;
      buf_b  <= gram_d_b;
      buf_r  <= gram_d_r;
      buf_g  <= gram_d_g;
    end
  end

  // Shifter, bit counter, palette lookup and underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_b     <= 8'd0;
      sh_r     <= 8'd0;
      sh_g     <= 8'd0;
      sh_valid <= 1'b0;
      bit_cnt  <= 3'd0;
      b        <= 1'b0;
      r        <= 1'b0;
      g        <= 1'b0;
      underrun <= 1'b0;
    end else if (line_start) begin
      sh_valid <= 1'b0;
      bit_cnt  <= 3'd0;
      underrun <= 1'b0;
      if (ce_pix) begin
        b <= 1'b0;
        r <= 1'b0;
        g <= 1'b0;
      end
    end else begin
      // A transfer only happens with an empty shifter, so it never collides
      // with a shift; a coincident enable sees the old (empty) shifter.
      if (xfer) begin
        sh_b     <= buf_b;
        sh_r     <= buf_r;
        sh_g     <= buf_g;
        sh_valid <= 1'b1;
      end
      if (ce_pix) begin
        if (active) begin
          if (sh_valid) begin
            b    <= pal_b[idx];
            r    <= pal_r[idx];
            g    <= pal_g[idx];
            sh_b <= {sh_b[6:0], 1'b0};
            sh_r <= {sh_r[6:0], 1'b0};
            sh_g <= {sh_g[6:0], 1'b0};
          end else begin
            b        <= 1'b0;
            r        <= 1'b0;
            g        <= 1'b0;
            underrun <= 1'b1;
          end
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            sh_valid <= 1'b0;
          end
        end else begin
          b <= 1'b0;
          r <= 1'b0;
          g <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_x1_gram_shifter.sv
`default_nettype none

module tb_x1_gram_shifter;

  logic        clk;
  logic        rst_n;
  logic        ce_pix;
  logic        line_start;
  logic [13:0] row_base;
  logic        active;
  logic [7:0]  pal_b;
  logic [7:0]  pal_r;
  logic [7:0]  pal_g;

  logic [13:0] gram_a;
  logic [7:0]  d_b, d_r, d_g;
  logic        b, r, g, underrun;

  logic [13:0] gram_a7;
  logic [7:0]  d_b7, d_r7, d_g7;
  logic        b7, r7, g7, underrun7;

  int total;
  int bad;

  logic [13:0] ap2 [2];
  logic [13:0] ap7 [7];
  logic [13:0] alog [$];
  logic [13:0] last_a;
  int          base_idx;

  x1_gram_shifter #(.RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .line_start(line_start),
    .row_base(row_base), .active(active), .gram_a(gram_a),
    .gram_d_b(d_b), .gram_d_r(d_r), .gram_d_g(d_g),
    .pal_b(pal_b), .pal_r(pal_r), .pal_g(pal_g),
    .b(b), .r(r), .g(g), .underrun(underrun)
  );

  x1_gram_shifter #(.RD_LAT(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .line_start(line_start),
    .row_base(row_base), .active(active), .gram_a(gram_a7),
    .gram_d_b(d_b7), .gram_d_r(d_r7), .gram_d_g(d_g7),
    .pal_b(pal_b), .pal_r(pal_r), .pal_g(pal_g),
    .b(b7), .r(r7), .g(g7), .underrun(underrun7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GRAM contents: 0x0100 holds the reference pattern, elsewhere address-derived.
  function automatic logic [7:0] mem_b(input logic [13:0] a);
    return (a == 14'h0100) ? 8'hF0 : a[7:0];
  endfunction
  function automatic logic [7:0] mem_r(input logic [13:0] a);
    return (a == 14'h0100) ? 8'hCC : (a[7:0] ^ 8'h5A);
  endfunction
  function automatic logic [7:0] mem_g(input logic [13:0] a);
    return (a == 14'h0100) ? 8'hAA : ~a[7:0];
  endfunction

  // Read-latency pipelines: data is valid RD_LAT cycles after the address.
  always @(posedge clk) begin
    ap2[0] <= gram_a;
    ap2[1] <= ap2[0];
    ap7[0] <= gram_a7;
    for (int k = 1; k < 7; k++) ap7[k] <= ap7[k-1];
  end
  assign d_b  = mem_b(ap2[1]);
  assign d_r  = mem_r(ap2[1]);
  assign d_g  = mem_g(ap2[1]);
  assign d_b7 = mem_b(ap7[6]);
  assign d_r7 = mem_r(ap7[6]);
  assign d_g7 = mem_g(ap7[6]);

  // Log every distinct address the RD_LAT=2 instance presents.
  initial last_a = 14'h0;
  always @(negedge clk) begin
    if (gram_a !== last_a) begin
      alog.push_back(gram_a);
      last_a = gram_a;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_line(input logic [13:0] base, input logic with_ce);
    line_start = 1'b1;
    row_base   = base;
    ce_pix     = with_ce;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    ce_pix     = 1'b0;
    base_idx   = alog.size();
  endtask

  task automatic pix(input logic a, input int period, output logic [2:0] o, output logic [2:0] o7);
    ce_pix = 1'b1;
    active = a;
    @(posedge clk);
    #1;
    ce_pix = 1'b0;
    o  = {g, r, b};
    o7 = {g7, r7, b7};
    repeat (period - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({gram_a, g, r, b, underrun} !== 18'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {gram_a, g, r, b, underrun});
    end
    rst_n = 1'b1;
    tick(3);
    total++;
    if (gram_a !== 14'd0 || {g, r, b} !== 3'd0) begin
      bad++;
      $display("FAIL reset_idle got a=%h px=%0d exp a=0 px=0", gram_a, {g, r, b});
    end
  endtask

  task automatic test_basic;
    logic [2:0] exp [8] = '{3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};
    logic [13:0] expa [3] = '{14'h0100, 14'h0101, 14'h0102};
    logic [2:0] o, o7;
    start_line(14'h0100, 1'b0);
    tick(4);
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, 4, o, o7);
      total++;
      if (o !== exp[i]) begin
        bad++;
        $display("FAIL basic_pix%0d got=%0d exp=%0d", i, o, exp[i]);
      end
    end
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL basic_underrun got=%b exp=0", underrun);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (alog.size() <= base_idx + i || alog[base_idx + i] !== expa[i]) begin
        bad++;
        $display("FAIL basic_addr%0d got=%h exp=%h", i,
                 (alog.size() > base_idx + i) ? alog[base_idx + i] : 14'h0, expa[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [2:0] exp [16] = '{3'd3, 3'd1, 3'd3, 3'd1, 3'd1, 3'd3, 3'd1, 3'd3,
                             3'd4, 3'd6, 3'd4, 3'd6, 3'd6, 3'd4, 3'd6, 3'd4};
    logic [13:0] expa [3] = '{14'h3FFF, 14'h0000, 14'h0001};
    logic [2:0] o, o7;
    start_line(14'h3FFF, 1'b0);
    tick(4);
    for (int i = 0; i < 16; i++) begin
      pix(1'b1, 4, o, o7);
      total++;
      if (o !== exp[i]) begin
        bad++;
        $display("FAIL wrap_pix%0d got=%0d exp=%0d", i, o, exp[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (alog.size() <= base_idx + i || alog[base_idx + i] !== expa[i]) begin
        bad++;
        $display("FAIL wrap_addr%0d got=%h exp=%h", i,
                 (alog.size() > base_idx + i) ? alog[base_idx + i] : 14'h0, expa[i]);
      end
    end
    // Line start coinciding with a pixel enable emits black.
    active = 1'b1;
    start_line(14'h0100, 1'b1);
    total++;
    if ({g, r, b} !== 3'd0) begin
      bad++;
      $display("FAIL ls_ce_pix got=%0d exp=0", {g, r, b});
    end
  endtask

  task automatic test_blank;
    logic [2:0] exp [13] = '{3'd7, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                             3'd1, 3'd6, 3'd2, 3'd4, 3'd0};
    logic [2:0] o, o7;
    start_line(14'h0100, 1'b0);
    tick(4);
    for (int i = 0; i < 13; i++) begin
      pix((i < 3 || i > 7), 4, o, o7);
      total++;
      if (o !== exp[i]) begin
        bad++;
        $display("FAIL blank_pix%0d got=%0d exp=%0d", i, o, exp[i]);
      end
    end
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL blank_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_underrun;
    logic [2:0] o, o7;
    start_line(14'h0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pix(1'b1, 1, o, o7);
      total++;
      if (o7 !== 3'd0 || underrun7 !== 1'b1) begin
        bad++;
        $display("FAIL underrun_pix%0d got px=%0d flag=%b exp px=0 flag=1", i, o7, underrun7);
      end
    end
    active = 1'b0;
    tick(2);
    start_line(14'h0100, 1'b0);
    total++;
    if (underrun7 !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear got=%b exp=0", underrun7);
    end
  endtask

  task automatic test_restart;
    logic [2:0] exp [8] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd6, 3'd4, 3'd6, 3'd4};
    logic [13:0] expa [2] = '{14'h0200, 14'h0201};
    logic [2:0] o, o7;
    start_line(14'h0100, 1'b0);
    tick(1);
    start_line(14'h0200, 1'b0);
    tick(4);
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, 4, o, o7);
      total++;
      if (o !== exp[i]) begin
        bad++;
        $display("FAIL restart_pix%0d got=%0d exp=%0d", i, o, exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (alog.size() <= base_idx + i || alog[base_idx + i] !== expa[i]) begin
        bad++;
        $display("FAIL restart_addr%0d got=%h exp=%h", i,
                 (alog.size() > base_idx + i) ? alog[base_idx + i] : 14'h0, expa[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [2:0] o, o7;
    start_line(14'h0100, 1'b0);
    tick(4);
    for (int i = 0; i < 3; i++) pix(1'b1, 4, o, o7);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({gram_a, g, r, b, underrun} !== 18'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {gram_a, g, r, b, underrun});
    end
    #3;
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      pix(1'b1, 2, o, o7);
      total++;
      if (o !== 3'd0) begin
        bad++;
        $display("FAIL post_reset_pix%0d got=%0d exp=0", i, o);
      end
    end
    total++;
    if (gram_a !== 14'd0) begin
      bad++;
      $display("FAIL post_reset_addr got=%h exp=0", gram_a);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    base_idx   = 0;
    rst_n      = 1'b0;
    ce_pix     = 1'b0;
    line_start = 1'b0;
    row_base   = 14'd0;
    active     = 1'b0;
    pal_b      = 8'hAA;
    pal_r      = 8'hCC;
    pal_g      = 8'hF0;
    test_reset();
    test_basic();
    test_wrap();
    test_blank();
    test_underrun();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
